// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Initiator side of the core's data-memory interface. Accepts one decoded
// load/store at a time from the execute stage and forms the effective address
// (rs1_val + imm, wrapping mod 2^32). It checks alignment and range, drives
// dataMem for the access and returns load data through a one-cycle writeback
// pulse.
//
// Optional feature macro: LSU_TIMEOUT_EN
//   defined   - ACCESS aborts with cause 2'b11 after TIMEOUT_CYCLES cycles
//               without the matching *_memory_avalible strobe.
//   undefined - ACCESS waits indefinitely; cause 2'b11 is never produced.
//
// Ports
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   issue_valid/ready      handshake with execute; ready only in IDLE
//   Single_Instruction     decoded one-hot instruction word (INST_* params)
//   rs1_val, rs2_val, imm  base, store data, sign-extended offset
//   rd                     load destination register
//   mem_instruction        to dataMem; 64'h0 outside ACCESS
//   mem_address            to dataMem, effective address
//   mem_storeData          to dataMem, store data
//   mem_loadData           from dataMem, already sign/zero extended
//   LD/SD_memory_avalible  dataMem ready for load / store
//   wb_valid, wb_rd, wb_data   load writeback pulse
//   st_done                store committed pulse
//   fault_valid, fault_cause, fault_addr   abort pulse
//                          (01 misaligned, 10 out of range, 11 timeout)
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 32'd16384,
`ifdef LSU_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 32'd16,
`endif
  parameter logic [63:0] INST_LB  = 64'h0000_0000_0000_0008,
  parameter logic [63:0] INST_LH  = 64'h0000_0000_0000_0010,
  parameter logic [63:0] INST_LW  = 64'h0000_0000_0000_0020,
  parameter logic [63:0] INST_LBU = 64'h0000_0000_0000_0040,
  parameter logic [63:0] INST_LHU = 64'h0000_0000_0000_0080,
  parameter logic [63:0] INST_SB  = 64'h0000_0000_0000_0100,
  parameter logic [63:0] INST_SH  = 64'h0000_0000_0000_0200,
  parameter logic [63:0] INST_SW  = 64'h0000_0000_0000_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [63:0] Single_Instruction,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  input  logic [4:0]  rd,
  output logic [63:0] mem_instruction,
  output logic [31:0] mem_address,
  output logic [31:0] mem_storeData,
  input  logic [31:0] mem_loadData,
  input  logic        LD_memory_avalible,
  input  logic        SD_memory_avalible,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        st_done,
  output logic        fault_valid,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WB     = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;
`ifdef LSU_TIMEOUT_EN
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
`endif

  // Decode helpers over the one-hot instruction constants.
  function automatic logic is_load_op(input logic [63:0] ins);
    return (ins == INST_LB) || (ins == INST_LH) || (ins == INST_LW) ||
           (ins == INST_LBU) || (ins == INST_LHU);
  endfunction

  function automatic logic is_store_op(input logic [63:0] ins);
    return (ins == INST_SB) || (ins == INST_SH) || (ins == INST_SW);
  endfunction

  // Halfwords need ea[0]==0, words need ea[1:0]==0; bytes never misalign.
  function automatic logic is_misaligned(input logic [63:0] ins, input logic [31:0] ea);
    logic half_op;
    logic word_op;
    half_op = (ins == INST_LH) || (ins == INST_LHU) || (ins == INST_SH);
    word_op = (ins == INST_LW) || (ins == INST_SW);
    return (half_op && ea[0]) || (word_op && (ea[1:0] != 2'b00));
  endfunction

  state_t      state_q, state_d;
  logic [63:0] instr_q, instr_d;
  logic [31:0] ea_q, ea_d;
  logic [31:0] stdata_q, stdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        issue_ready_q, issue_ready_d;
  logic [63:0] mem_instruction_q, mem_instruction_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        st_done_q, st_done_d;
  logic        fault_valid_q, fault_valid_d;
  logic [1:0]  fault_cause_q, fault_cause_d;
  logic [31:0] fault_addr_q, fault_addr_d;
`ifdef LSU_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic [31:0] ea_s;
  logic        is_load_s;
  logic        avail_s;

  // Carry out of the address add is dropped on purpose (wrap mod 2^32).
  assign ea_s      = rs1_val + imm;
  assign is_load_s = is_load_op(instr_q);
  assign avail_s   = is_load_s ? LD_memory_avalible : SD_memory_avalible;

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d           = state_q;
    instr_d           = instr_q;
    ea_d              = ea_q;
    stdata_d          = stdata_q;
    rd_d              = rd_q;
    mem_instruction_d = 64'h0;
    wb_valid_d        = 1'b0;
    wb_rd_d           = wb_rd_q;
    wb_data_d         = wb_data_q;
    st_done_d         = 1'b0;
    fault_valid_d     = 1'b0;
    fault_cause_d     = fault_cause_q;
    fault_addr_d      = fault_addr_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d             = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        // issue_ready_q gates acceptance so nothing is taken on the first
        // edge after reset release, when ready is still low.
        if (issue_valid && issue_ready_q &&
            (is_load_op(Single_Instruction) || is_store_op(Single_Instruction))) begin
          instr_d  = Single_Instruction;
          ea_d     = ea_s;
          stdata_d = rs2_val;
          rd_d     = rd;
          if (is_misaligned(Single_Instruction, ea_s)) begin
            state_d       = FAULT;
            fault_valid_d = 1'b1;
            fault_cause_d = CAUSE_MISALIGN;
            fault_addr_d  = ea_s;
          end else if (ea_s >= MEM_BYTES) begin
            state_d       = FAULT;
            fault_valid_d = 1'b1;
            fault_cause_d = CAUSE_RANGE;
            fault_addr_d  = ea_s;
          end else begin
            state_d           = ACCESS;
            mem_instruction_d = Single_Instruction;
`ifdef LSU_TIMEOUT_EN
            cnt_d             = {CNT_W{1'b0}};
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end

      ACCESS: begin
        // The edge on which avalible is high is the dataMem access edge.
        if (avail_s) begin
          mem_instruction_d = 64'h0;
          if (is_load_s) begin
            state_d = WB;
            if (rd_q != 5'd0) begin
              wb_valid_d = 1'b1;
              wb_rd_d    = rd_q;
              wb_data_d  = mem_loadData;
            end else begin
              wb_valid_d = 1'b0;
            end
          end else begin
            state_d   = IDLE;
            st_done_d = 1'b1;
          end
        end else begin
`ifdef LSU_TIMEOUT_EN
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 32'd1)) begin
            state_d           = FAULT;
            mem_instruction_d = 64'h0;
            fault_valid_d     = 1'b1;
            fault_cause_d     = CAUSE_TIMEOUT;
            fault_addr_d      = ea_q;
          end else begin
            mem_instruction_d = instr_q;
            cnt_d             = cnt_q + CNT_W'(1);
          end
`else
          mem_instruction_d = instr_q;
`endif
        end
      end

      // The writeback / fault pulse is the registered output of these states.
      WB: begin
        state_d = IDLE;
      end

      FAULT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    issue_ready_d = (state_d == IDLE);
  end

  // State, latched operands and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      instr_q           <= 64'h0;
      ea_q              <= 32'h0;
      stdata_q          <= 32'h0;
      rd_q              <= 5'd0;
      issue_ready_q     <= 1'b0;
      mem_instruction_q <= 64'h0;
      wb_valid_q        <= 1'b0;
      wb_rd_q           <= 5'd0;
      wb_data_q         <= 32'h0;
      st_done_q         <= 1'b0;
      fault_valid_q     <= 1'b0;
      fault_cause_q     <= 2'b00;
      fault_addr_q      <= 32'h0;
`ifdef LSU_TIMEOUT_EN
      cnt_q             <= {CNT_W{1'b0}};
`endif
    end else begin
      state_q           <= state_d;
      instr_q           <= instr_d;
      ea_q              <= ea_d;
      stdata_q          <= stdata_d;
      rd_q              <= rd_d;
      issue_ready_q     <= issue_ready_d;
      mem_instruction_q <= mem_instruction_d;
      wb_valid_q        <= wb_valid_d;
      wb_rd_q           <= wb_rd_d;
      wb_data_q         <= wb_data_d;
      st_done_q         <= st_done_d;
      fault_valid_q     <= fault_valid_d;
      fault_cause_q     <= fault_cause_d;
      fault_addr_q      <= fault_addr_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q             <= cnt_d;
`endif
    end
  end

  assign issue_ready     = issue_ready_q;
  assign mem_instruction = mem_instruction_q;
  assign mem_address     = ea_q;
  assign mem_storeData   = stdata_q;
  assign wb_valid        = wb_valid_q;
  assign wb_rd           = wb_rd_q;
  assign wb_data         = wb_data_q;
  assign st_done         = st_done_q;
  assign fault_valid     = fault_valid_q;
  assign fault_cause     = fault_cause_q;
  assign fault_addr      = fault_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam logic [63:0] INST_LB  = 64'h0000_0000_0000_0008;
  localparam logic [63:0] INST_LH  = 64'h0000_0000_0000_0010;
  localparam logic [63:0] INST_LW  = 64'h0000_0000_0000_0020;
  localparam logic [63:0] INST_LBU = 64'h0000_0000_0000_0040;
  localparam logic [63:0] INST_LHU = 64'h0000_0000_0000_0080;
  localparam logic [63:0] INST_SB  = 64'h0000_0000_0000_0100;
  localparam logic [63:0] INST_SH  = 64'h0000_0000_0000_0200;
  localparam logic [63:0] INST_SW  = 64'h0000_0000_0000_0400;
  localparam logic [63:0] INST_ADD = 64'h0000_0000_0000_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [63:0] Single_Instruction;
  logic [31:0] rs1_val, rs2_val, imm;
  logic [4:0]  rd;
  logic [63:0] mem_instruction;
  logic [31:0] mem_address, mem_storeData, mem_loadData;
  logic        LD_memory_avalible, SD_memory_avalible;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        st_done;
  logic        fault_valid;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  logic [31:0] dmem [0:4095];
  logic [31:0] ld_word, sh_b, sh_h;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .Single_Instruction(Single_Instruction),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .rd(rd),
    .mem_instruction(mem_instruction), .mem_address(mem_address),
    .mem_storeData(mem_storeData), .mem_loadData(mem_loadData),
    .LD_memory_avalible(LD_memory_avalible), .SD_memory_avalible(SD_memory_avalible),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .st_done(st_done),
    .fault_valid(fault_valid), .fault_cause(fault_cause), .fault_addr(fault_addr)
  );

  // dataMem stand-in: writes on the clock edge while a store is presented.
  always @(posedge clk) begin
    if (SD_memory_avalible) begin
      case (mem_instruction)
        INST_SW: dmem[mem_address[13:2]] <= mem_storeData;
        INST_SH: begin
          if (mem_address[1]) dmem[mem_address[13:2]][31:16] <= mem_storeData[15:0];
          else                dmem[mem_address[13:2]][15:0]  <= mem_storeData[15:0];
        end
        INST_SB: begin
          case (mem_address[1:0])
            2'd0: dmem[mem_address[13:2]][7:0]   <= mem_storeData[7:0];
            2'd1: dmem[mem_address[13:2]][15:8]  <= mem_storeData[7:0];
            2'd2: dmem[mem_address[13:2]][23:16] <= mem_storeData[7:0];
            default: dmem[mem_address[13:2]][31:24] <= mem_storeData[7:0];
          endcase
        end
        default: ;
      endcase
    end
  end

  // dataMem stand-in: combinational, extended load data.
  always_comb begin
    ld_word = dmem[mem_address[13:2]];
    sh_b    = ld_word >> {mem_address[1:0], 3'b000};
    sh_h    = ld_word >> {mem_address[1], 4'b0000};
    case (mem_instruction)
      INST_LB:  mem_loadData = {{24{sh_b[7]}}, sh_b[7:0]};
      INST_LBU: mem_loadData = {24'h0, sh_b[7:0]};
      INST_LH:  mem_loadData = {{16{sh_h[15]}}, sh_h[15:0]};
      INST_LHU: mem_loadData = {16'h0, sh_h[15:0]};
      INST_LW:  mem_loadData = ld_word;
      default:  mem_loadData = 32'h0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction and returns #1 after its accept edge.
  task automatic issue(input logic [63:0] ins, input logic [31:0] r1, input logic [31:0] im,
                       input logic [31:0] r2, input logic [4:0] d);
    Single_Instruction = ins;
    rs1_val = r1;
    imm = im;
    rs2_val = r2;
    rd = d;
    issue_valid = 1'b1;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    Single_Instruction = 64'h0;
  endtask

  task automatic do_store(input string tag, input logic [63:0] ins, input logic [31:0] r1,
                          input logic [31:0] im, input logic [31:0] r2);
    issue(ins, r1, im, r2, 5'd0);
    tick();
    check({tag, "_st_done"}, {63'h0, st_done}, 64'h1);
  endtask

  task automatic do_load(input string tag, input logic [63:0] ins, input logic [31:0] r1,
                         input logic [31:0] im, input logic [4:0] d, input logic [31:0] exp);
    issue(ins, r1, im, 32'h0, d);
    tick();
    check({tag, "_wb_valid"}, {63'h0, wb_valid}, 64'h1);
    check({tag, "_wb_data"}, {32'h0, wb_data}, {32'h0, exp});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) dmem[i] = 32'h0;
    reset = 1'b1;
    issue_valid = 1'b0;
    Single_Instruction = 64'h0;
    rs1_val = 32'h0;
    rs2_val = 32'h0;
    imm = 32'h0;
    rd = 5'd0;
    LD_memory_avalible = 1'b1;
    SD_memory_avalible = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_ready", {63'h0, issue_ready}, 64'h0);
    check("rst_mem_instr", mem_instruction, 64'h0);
    check("rst_wb_valid", {63'h0, wb_valid}, 64'h0);
    check("rst_fault_valid", {63'h0, fault_valid}, 64'h0);
    check("rst_st_done", {63'h0, st_done}, 64'h0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", {63'h0, issue_ready}, 64'h1);

    // 1: SW then LW of the same word
    issue(INST_SW, 32'h100, 32'h4, 32'hDEADBEEF, 5'd0);
    check("t1_sw_instr", mem_instruction, INST_SW);
    check("t1_sw_addr", {32'h0, mem_address}, 64'h104);
    check("t1_sw_data", {32'h0, mem_storeData}, 64'hDEADBEEF);
    check("t1_sw_ready", {63'h0, issue_ready}, 64'h0);
    tick();
    check("t1_st_done", {63'h0, st_done}, 64'h1);
    check("t1_instr_cleared", mem_instruction, 64'h0);
    check("t1_word41", {32'h0, dmem[32'h41]}, 64'hDEADBEEF);
    issue(INST_LW, 32'h100, 32'h4, 32'h0, 5'd5);
    check("t1_lw_no_early_wb", {63'h0, wb_valid}, 64'h0);
    check("t1_st_done_single", {63'h0, st_done}, 64'h0);
    tick();
    check("t1_lw_wb_valid", {63'h0, wb_valid}, 64'h1);
    check("t1_lw_wb_rd", {59'h0, wb_rd}, 64'h5);
    check("t1_lw_wb_data", {32'h0, wb_data}, 64'hDEADBEEF);
    tick();
    check("t1_wb_pulse_end", {63'h0, wb_valid}, 64'h0);
    check("t1_ready_again", {63'h0, issue_ready}, 64'h1);

    // 2: byte store and sub-word loads
    do_store("t2_sb", INST_SB, 32'h100, 32'h5, 32'h80);
    check("t2_word41", {32'h0, dmem[32'h41]}, 64'hDEAD80EF);
    do_load("t2_lb", INST_LB, 32'h100, 32'h5, 5'd7, 32'hFFFFFF80);
    do_load("t2_lbu", INST_LBU, 32'h100, 32'h5, 5'd7, 32'h00000080);
    do_load("t2_lw", INST_LW, 32'h104, 32'h0, 5'd8, 32'hDEAD80EF);
    do_load("t2_lh", INST_LH, 32'h104, 32'h2, 5'd8, 32'hFFFFDEAD);
    do_load("t2_lhu", INST_LHU, 32'h104, 32'h2, 5'd8, 32'h0000DEAD);

    // 3: misaligned accesses
    issue(INST_LH, 32'h100, 32'h3, 32'h0, 5'd4);
    check("t3_fault_valid", {63'h0, fault_valid}, 64'h1);
    check("t3_fault_cause", {62'h0, fault_cause}, 64'h1);
    check("t3_fault_addr", {32'h0, fault_addr}, 64'h103);
    check("t3_no_access", mem_instruction, 64'h0);
    check("t3_no_wb", {63'h0, wb_valid}, 64'h0);
    tick();
    check("t3_fault_pulse_end", {63'h0, fault_valid}, 64'h0);
    check("t3_ready_again", {63'h0, issue_ready}, 64'h1);
    issue(INST_LW, 32'h4000, 32'h1, 32'h0, 5'd4);
    check("t3_both_cause", {62'h0, fault_cause}, 64'h1);
    tick();

    // 4: range check and address wrap
    issue(INST_SW, 32'h4000, 32'h0, 32'h11111111, 5'd0);
    check("t4_range_valid", {63'h0, fault_valid}, 64'h1);
    check("t4_range_cause", {62'h0, fault_cause}, 64'h2);
    check("t4_range_addr", {32'h0, fault_addr}, 64'h4000);
    check("t4_range_no_access", mem_instruction, 64'h0);
    tick();
    check("t4_word0_unchanged", {32'h0, dmem[32'h0]}, 64'h0);
    do_store("t4_wrap", INST_SW, 32'hFFFFFFFC, 32'h8, 32'h12345678);
    check("t4_word1", {32'h0, dmem[32'h1]}, 64'h12345678);
    do_store("t4_top_sb", INST_SB, 32'h3FFF, 32'h0, 32'hA5);
    check("t4_word4095", {32'h0, dmem[32'd4095]}, 64'hA5000000);
    do_load("t4_top_lbu", INST_LBU, 32'h3FFF, 32'h0, 5'd3, 32'h000000A5);
    issue(INST_LB, 32'h3FFF, 32'h1, 32'h0, 5'd3);
    check("t4_byte_range_cause", {62'h0, fault_cause}, 64'h2);
    tick();

    // 5: load stalled by LD_memory_avalible
    LD_memory_avalible = 1'b0;
    issue(INST_LW, 32'h100, 32'h4, 32'h0, 5'd9);
    repeat (5) tick();
    check("t5_wait_no_wb", {63'h0, wb_valid}, 64'h0);
    check("t5_wait_instr", mem_instruction, INST_LW);
    check("t5_wait_addr", {32'h0, mem_address}, 64'h104);
    LD_memory_avalible = 1'b1;
    tick();
    check("t5_late_wb_valid", {63'h0, wb_valid}, 64'h1);
    check("t5_late_wb_data", {32'h0, wb_data}, 64'hDEAD80EF);
    check("t5_late_wb_rd", {59'h0, wb_rd}, 64'h9);
    tick();

    LD_memory_avalible = 1'b0;
    issue(INST_LW, 32'h100, 32'h4, 32'h0, 5'd9);
`ifdef LSU_TIMEOUT_EN
    repeat (15) tick();
    check("t5_to_not_yet", {63'h0, fault_valid}, 64'h0);
    check("t5_to_still_access", mem_instruction, INST_LW);
    tick();
    check("t5_to_fault_valid", {63'h0, fault_valid}, 64'h1);
    check("t5_to_cause", {62'h0, fault_cause}, 64'h3);
    check("t5_to_addr", {32'h0, fault_addr}, 64'h104);
    check("t5_to_no_wb", {63'h0, wb_valid}, 64'h0);
    check("t5_to_instr_cleared", mem_instruction, 64'h0);
    LD_memory_avalible = 1'b1;
    tick();
    check("t5_to_ready", {63'h0, issue_ready}, 64'h1);
`else
    repeat (20) tick();
    check("t5_hold_no_fault", {63'h0, fault_valid}, 64'h0);
    check("t5_hold_instr", mem_instruction, INST_LW);
    check("t5_hold_no_wb", {63'h0, wb_valid}, 64'h0);
    LD_memory_avalible = 1'b1;
    tick();
    check("t5_hold_wb_valid", {63'h0, wb_valid}, 64'h1);
    tick();
`endif

    // 6: reset during a store access, then a load to x0
    issue(INST_SW, 32'h100, 32'h4, 32'hCAFEF00D, 5'd0);
    check("t6_sw_instr", mem_instruction, INST_SW);
    #1;
    reset = 1'b1;
    #1;
    check("t6_rst_instr_async", mem_instruction, 64'h0);
    check("t6_rst_ready", {63'h0, issue_ready}, 64'h0);
    @(posedge clk);
    #1;
    check("t6_word_unchanged", {32'h0, dmem[32'h41]}, 64'hDEAD80EF);
    check("t6_no_st_done", {63'h0, st_done}, 64'h0);
    reset = 1'b0;
    tick();
    check("t6_ready_after_rst", {63'h0, issue_ready}, 64'h1);
    issue(INST_LW, 32'h100, 32'h4, 32'h0, 5'd0);
    check("t6_x0_access", mem_instruction, INST_LW);
    tick();
    check("t6_x0_no_wb", {63'h0, wb_valid}, 64'h0);
    tick();
    check("t6_x0_no_wb_late", {63'h0, wb_valid}, 64'h0);
    check("t6_x0_ready", {63'h0, issue_ready}, 64'h1);

    // Non-memory instruction is ignored
    issue(INST_ADD, 32'h100, 32'h4, 32'h0, 5'd5);
    check("t7_ignore_ready", {63'h0, issue_ready}, 64'h1);
    check("t7_ignore_instr", mem_instruction, 64'h0);
    check("t7_ignore_fault", {63'h0, fault_valid}, 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
